// File: rtl/scr1_dmi_hs.sv
// DMI handshake bridge: TAP-side DTMCS / DMI_ACCESS shift register plus a req/resp FSM toward the Debug Module.
// Define SCR1_DMI_HS_TIMEOUT_EN to abandon a DM request that gets no response within TIMEOUT_CYCLES.
module scr1_dmi_hs #(
  parameter int unsigned ADDR_WIDTH     = 7,
  parameter int unsigned IDLE_HINT      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tapcsync2dmi_ch_sel_i,
  input  logic [1:0]            tapcsync2dmi_ch_id_i,
  input  logic                  tapcsync2dmi_ch_capture_i,
  input  logic                  tapcsync2dmi_ch_shift_i,
  input  logic                  tapcsync2dmi_ch_update_i,
  input  logic                  tapcsync2dmi_ch_tdi_i,
  output logic                  dmi2tapcsync_ch_tdo_o,
  output logic                  dmi2dm_req_o,
  output logic                  dmi2dm_wr_o,
  output logic [ADDR_WIDTH-1:0] dmi2dm_addr_o,
  output logic [31:0]           dmi2dm_wdata_o,
  input  logic                  dm2dmi_resp_i,
  input  logic                  dm2dmi_err_i,
  input  logic [31:0]           dm2dmi_rdata_i
);

  localparam int unsigned DMI_W   = ADDR_WIDTH + 34;
  localparam logic [1:0]  ID_DTMCS = 2'd1;
  localparam logic [1:0]  ID_DMI   = 2'd2;
  localparam logic [1:0]  OP_RD    = 2'd1;
  localparam logic [1:0]  OP_WR    = 2'd2;
  localparam logic [1:0]  ST_OK    = 2'd0;
  localparam logic [1:0]  ST_FAIL  = 2'd2;
  localparam logic [1:0]  ST_BUSY  = 2'd3;
  localparam logic [2:0]  IDLE_F   = 3'(IDLE_HINT);
  localparam logic [5:0]  ABITS_F  = 6'(ADDR_WIDTH);

  if (ADDR_WIDTH < 7 || ADDR_WIDTH > 16 || IDLE_HINT > 7 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("scr1_dmi_hs: illegal parameter value");
  end

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                state_q, state_d;
  logic [DMI_W-1:0]      sr_q, sr_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [1:0]            sticky_q, sticky_d;

  logic                  is_dtmcs, is_dmi, busy;
  logic                  cap_dtmcs, cap_dmi, shift_dtmcs, shift_dmi, upd_dtmcs, upd_dmi;
  logic                  hard_reset, status_clr, dmi_start, resp_taken, timeout;
  logic [1:0]            upd_op;
  logic [31:0]           upd_data;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [31:0]           dtmcs_cap;
  logic [DMI_W-1:0]      dmi_cap;

  assign is_dtmcs    = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == ID_DTMCS);
  assign is_dmi      = tapcsync2dmi_ch_sel_i & (tapcsync2dmi_ch_id_i == ID_DMI);
  assign cap_dtmcs   = is_dtmcs & tapcsync2dmi_ch_capture_i;
  assign cap_dmi     = is_dmi   & tapcsync2dmi_ch_capture_i;
  assign shift_dtmcs = is_dtmcs & tapcsync2dmi_ch_shift_i;
  assign shift_dmi   = is_dmi   & tapcsync2dmi_ch_shift_i;
  assign upd_dtmcs   = is_dtmcs & tapcsync2dmi_ch_update_i;
  assign upd_dmi     = is_dmi   & tapcsync2dmi_ch_update_i;

  assign busy     = (state_q == S_BUSY);
  assign upd_op   = sr_q[1:0];
  assign upd_data = sr_q[33:2];
  assign upd_addr = sr_q[DMI_W-1:34];

  // dmihardreset (bit 17) also aborts the in-flight request; dmireset (bit 16) only clears status
  assign hard_reset = upd_dtmcs & sr_q[17];
  assign status_clr = upd_dtmcs & (sr_q[16] | sr_q[17]);
  assign dmi_start  = upd_dmi & ~busy & (sticky_q == ST_OK) & ((upd_op == OP_RD) | (upd_op == OP_WR));
  assign resp_taken = busy & dm2dmi_resp_i & ~hard_reset;

  assign dtmcs_cap = {17'd0, IDLE_F, sticky_q, ABITS_F, 4'd1};
  assign dmi_cap   = {addr_q, data_q, (busy ? ST_BUSY : sticky_q)};

`ifdef SCR1_DMI_HS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Counts BUSY cycles already spent; the last allowed cycle is TIMEOUT_CYCLES-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!busy) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = busy & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dmi_start) state_d = S_BUSY;
      S_BUSY:  if (hard_reset || dm2dmi_resp_i || timeout) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dmi2dm_req_o   = 1'b0;
    dmi2dm_wr_o    = 1'b0;
    dmi2dm_addr_o  = '0;
    dmi2dm_wdata_o = '0;
    if (state_q == S_BUSY) begin
      dmi2dm_req_o   = 1'b1;
      dmi2dm_wr_o    = wr_q;
      dmi2dm_addr_o  = addr_q;
      dmi2dm_wdata_o = wdata_q;
    end
  end

  always_comb begin
    sr_d     = sr_q;
    data_d   = data_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    sticky_d = sticky_q;

    // TDI enters the MSB of whichever DR is selected; DTMCS keeps the upper bits clear
    if (cap_dtmcs) begin
      sr_d = {{(DMI_W-32){1'b0}}, dtmcs_cap};
    end else if (cap_dmi) begin
      sr_d = dmi_cap;
    end else if (shift_dtmcs) begin
      sr_d = {{(DMI_W-32){1'b0}}, tapcsync2dmi_ch_tdi_i, sr_q[31:1]};
    end else if (shift_dmi) begin
      sr_d = {tapcsync2dmi_ch_tdi_i, sr_q[DMI_W-1:1]};
    end

    if (dmi_start) begin
      addr_d  = upd_addr;
      wdata_d = upd_data;
      wr_d    = (upd_op == OP_WR);
    end

    if (resp_taken && !dm2dmi_err_i && !wr_q) begin
      data_d = dm2dmi_rdata_i;
    end

    // The first error condition latches; only dmireset/dmihardreset/rst clear it
    if (sticky_q == ST_OK) begin
      if (busy && (cap_dmi || upd_dmi)) begin
        sticky_d = ST_BUSY;
      end else if (busy && !hard_reset &&
                   ((dm2dmi_resp_i && dm2dmi_err_i) || (timeout && !dm2dmi_resp_i))) begin
        sticky_d = ST_FAIL;
      end
    end
    if (status_clr) begin
      sticky_d = ST_OK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q     <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      sticky_q <= ST_OK;
    end else begin
      sr_q     <= sr_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      sticky_q <= sticky_d;
    end
  end

  assign dmi2tapcsync_ch_tdo_o = sr_q[0];

endmodule

// File: tb/tb_scr1_dmi_hs.sv
// Scoreboard bench for scr1_dmi_hs: random and directed DTMCS/DMI scans against a transaction-level model.
`timescale 1ns/1ps
module tb_scr1_dmi_hs;
  localparam int AW = 7;
  localparam int DW = AW + 34;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic sel, cap, shf, upd, tdi;
  logic [1:0] id;
  logic tdo, req, wr;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  logic resp, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  scr1_dmi_hs #(.ADDR_WIDTH(AW), .IDLE_HINT(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .tapcsync2dmi_ch_sel_i(sel), .tapcsync2dmi_ch_id_i(id),
    .tapcsync2dmi_ch_capture_i(cap), .tapcsync2dmi_ch_shift_i(shf),
    .tapcsync2dmi_ch_update_i(upd), .tapcsync2dmi_ch_tdi_i(tdi),
    .dmi2tapcsync_ch_tdo_o(tdo),
    .dmi2dm_req_o(req), .dmi2dm_wr_o(wr), .dmi2dm_addr_o(addr), .dmi2dm_wdata_o(wdata),
    .dm2dmi_resp_i(resp), .dm2dmi_err_i(err), .dm2dmi_rdata_i(rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [63:0] val; string name; } cap_exp_t;
  typedef struct { logic w; logic [AW-1:0] a; logic [31:0] d; } req_exp_t;
  cap_exp_t cap_q[$];
  req_exp_t req_q[$];
  int       len_q[$];

  // Reference model: debug-transport state as seen by a debugger
  int            m_sticky = 0;
  bit            m_busy = 0;
  bit            m_rd = 0;
  logic [31:0]   m_data = '0;
  logic [AW-1:0] m_addr = '0;

  // DM responder configuration
  int          cfg_delay = 0;
  bit          cfg_err = 0;
  logic [31:0] cfg_rdata = '0;
  bit          kick = 0;

  task automatic do_resp();
    resp = 1'b1; err = cfg_err; rdata = cfg_rdata;
    if (m_busy) begin
      if (cfg_err) begin
        if (m_sticky == 0) m_sticky = 2;
      end else if (m_rd) begin
        m_data = cfg_rdata;
      end
      m_busy = 0;
      len_q.push_back(cfg_delay + 1);
    end
  endtask

  initial begin : dm_model
    int wcnt;
    wcnt = -1;
    resp = 1'b0; err = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      resp = 1'b0; err = 1'b0; rdata = '0;
      if (kick) begin
        kick = 0; wcnt = -1; do_resp();
      end else begin
        if (!req) wcnt = -1;
        else if (wcnt < 0) wcnt = 0;
        if (wcnt >= 0) begin
          if (wcnt == cfg_delay) begin wcnt = -1; do_resp(); end
          else wcnt++;
        end
      end
    end
  end

  initial begin : cap_mon
    logic [63:0] w;
    int n, width;
    bit on;
    on = 0; n = 0; width = 0; w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        on = 0;
      end else if (sel && cap) begin
        on = 1; n = 0; w = '0; width = (id == 2'd1) ? 32 : DW;
      end else if (on && sel && shf) begin
        w[n] = tdo; n++;
        if (n == width) begin
          on = 0;
          if (cap_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_capture: got 0x%0h, expected none", w);
          end else begin
            cap_exp_t e;
            e = cap_q.pop_front();
            check(e.name, w, e.val);
          end
        end
      end
    end
  end

  initial begin : req_mon
    bit prev, stable;
    int len;
    req_exp_t cur;
    prev = 0; stable = 1; len = 0;
    cur = '{w: 1'b0, a: '0, d: '0};
    forever begin
      @(negedge clk);
      if (req) begin
        if (!prev) begin
          len = 0; stable = 1;
          if (req_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_req: got addr 0x%0h wr %0d, expected none", addr, wr);
            cur = '{w: wr, a: addr, d: wdata};
          end else begin
            cur = req_q.pop_front();
            check("req_wr", 64'(wr), 64'(cur.w));
            check("req_addr", 64'(addr), 64'(cur.a));
            check("req_wdata", 64'(wdata), 64'(cur.d));
          end
        end else if ({wr, addr, wdata} !== {cur.w, cur.a, cur.d}) begin
          stable = 0;
        end
        len++;
      end else begin
        if (prev) begin
          check("req_stable", 64'(stable), 64'd1);
          if (len_q.size() != 0) check("req_len", 64'(len), 64'(len_q.pop_front()));
        end
        check("idle_outputs_zero", 64'({wr, addr, wdata}), 64'd0);
      end
      prev = req;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic jtag_capture_shift(input logic [1:0] cid, input logic [63:0] din);
    int w;
    w = (cid == 2'd1) ? 32 : DW;
    sel = 1'b1; id = cid; cap = 1'b1; tick(); cap = 1'b0;
    for (int i = 0; i < w; i++) begin
      shf = 1'b1; tdi = din[i]; tick();
    end
    shf = 1'b0; tdi = 1'b0;
  endtask

  task automatic jtag_update();
    upd = 1'b1; tick(); upd = 1'b0; sel = 1'b0;
  endtask

  task automatic dmi_scan(input logic [1:0] op, input logic [AW-1:0] a, input logic [31:0] d);
    logic [1:0] opf;
    logic [63:0] din;
    opf = m_busy ? 2'd3 : 2'(m_sticky);
    if (m_busy && m_sticky == 0) m_sticky = 3;
    cap_q.push_back('{val: 64'({m_addr, m_data, opf}), name: "dmi_capture"});
    din = 64'({a, d, op});
    jtag_capture_shift(2'd2, din);
    if (m_busy) begin
      if (m_sticky == 0) m_sticky = 3;
    end else if (m_sticky == 0 && (op == 2'd1 || op == 2'd2)) begin
      m_addr = a; m_rd = (op == 2'd1); m_busy = 1;
      req_q.push_back('{w: (op == 2'd2), a: a, d: d});
    end
    jtag_update();
    tick();
  endtask

  task automatic dtmcs_scan(input bit dmireset, input bit hardreset);
    logic [63:0] din;
    logic [1:0] st;
    st = 2'(m_sticky);
    cap_q.push_back('{val: {32'd0, 17'd0, 3'd1, st, 6'(AW), 4'd1}, name: "dtmcs_capture"});
    din = {32'd0, $urandom};
    din[16] = dmireset; din[17] = hardreset;
    jtag_capture_shift(2'd1, din);
    if (hardreset) begin m_sticky = 0; m_busy = 0; end
    else if (dmireset) m_sticky = 0;
    jtag_update();
    if (hardreset) check("hardreset_req_drop", 64'(req), 64'd0);
    tick();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (m_busy && t < 2000) begin tick(); t++; end
    if (m_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle: request still open after %0d cycles, expected response", t);
      m_busy = 0;
    end
    tick(); tick();
  endtask

  task automatic model_reset();
    m_sticky = 0; m_busy = 0; m_rd = 0; m_data = '0; m_addr = '0;
  endtask

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; sel = 0; id = 0; cap = 0; shf = 0; upd = 0; tdi = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", 64'(req), 64'd0);
    check("rst_outputs", 64'({wr, addr, wdata}), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Reset DTMCS word and empty DMI capture
    dtmcs_scan(0, 0);
    dmi_scan(2'd0, '0, '0);

    // Read addr 0x11, response after 3 cycles
    cfg_delay = 3; cfg_err = 0; cfg_rdata = 32'hDEADBEEF;
    dmi_scan(2'd1, 7'h11, 32'h0);
    wait_idle();
    dmi_scan(2'd0, '0, '0);

    // Read with error response
    cfg_delay = 1; cfg_err = 1; cfg_rdata = 32'h0BADF00D;
    dmi_scan(2'd1, 7'h05, 32'h0);
    wait_idle();
    dmi_scan(2'd0, '0, '0);
    dtmcs_scan(0, 0);
    dtmcs_scan(1, 0);

`ifndef SCR1_DMI_HS_TIMEOUT_EN
    // Write issued while a slow read is in flight is dropped and marks busy
    cfg_delay = 150; cfg_err = 0; cfg_rdata = 32'h13572468;
    dmi_scan(2'd1, 7'h22, 32'h0);
    dmi_scan(2'd2, 7'h10, 32'hCAFEF00D);
    wait_idle();
    dmi_scan(2'd2, 7'h10, 32'hCAFEF00D);
    dtmcs_scan(1, 0);
    cfg_delay = 2;
    dmi_scan(2'd2, 7'h10, 32'h12345678);
    wait_idle();
    dmi_scan(2'd0, '0, '0);

    // Hard reset aborts a request; the late response is ignored
    cfg_delay = 9999; cfg_err = 0; cfg_rdata = 32'hBAD0BAD0;
    dmi_scan(2'd1, 7'h33, 32'h0);
    dtmcs_scan(0, 1);
    tick();
    kick = 1;
    repeat (3) tick();
    dmi_scan(2'd0, '0, '0);
    cfg_delay = 0; cfg_rdata = 32'h55AA55AA;
    dmi_scan(2'd1, 7'h34, 32'h0);
    wait_idle();

    // Asynchronous reset while busy
    cfg_delay = 150;
    dmi_scan(2'd1, 7'h44, 32'h0);
    repeat (4) tick();
    rst = 1'b1; #1;
    check("rst_busy_req_drop", 64'(req), 64'd0);
    check("rst_busy_tdo", 64'(tdo), 64'd0);
    model_reset();
    repeat (2) tick();
    @(negedge clk); rst = 1'b0;
    tick();
    dtmcs_scan(0, 0);
    dmi_scan(2'd0, '0, '0);
`else
    // No response: the request is abandoned after TO busy cycles
    cfg_delay = 9999; cfg_err = 0;
    len_q.push_back(TO);
    dmi_scan(2'd1, 7'h2A, 32'h0);
    repeat (TO + 4) tick();
    m_busy = 0;
    if (m_sticky == 0) m_sticky = 2;
    dmi_scan(2'd0, '0, '0);
    dtmcs_scan(1, 0);
`endif

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 6) begin
        logic [1:0] op;
        op = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
        cfg_delay = $urandom_range(0, 6);
        cfg_err = ($urandom_range(0, 4) == 0);
        cfg_rdata = $urandom;
        dmi_scan(op, AW'($urandom), $urandom);
        wait_idle();
      end else if (act < 9) begin
        dtmcs_scan(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        wait_idle();
      end else begin
        dmi_scan(2'd0, AW'($urandom), $urandom);
      end
    end

    repeat (5) tick();
    check("leftover_captures", 64'(cap_q.size()), 64'd0);
    check("leftover_requests", 64'(req_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/scr1_dmi_hs.md
SCR1_DMI_HS -- requirements
Module: scr1_dmi_hs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, DMI address width (legal 7..16).
REQ-002 SHALL have parameter IDLE_HINT, default 1, value reported in dtmcs.idle (legal 0..7).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, DM response timeout in clk cycles (used only under REQ-029).
REQ-004 Ports; reset is asynchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- tapcsync2dmi_ch_sel_i  in  1  DMI channel selected.
- tapcsync2dmi_ch_id_i  in  2  channel ID (1 = DTMCS, 2 = DMI_ACCESS).
- tapcsync2dmi_ch_capture_i / _shift_i / _update_i  in  1 each  TAP DR phase strobes, one clk each.
- tapcsync2dmi_ch_tdi_i  in  1  serial data in.
- dmi2tapcsync_ch_tdo_o  out  1  serial data out.
- dmi2dm_req_o  out  1  request, held until response.
- dmi2dm_wr_o  out  1  1 = write.
- dmi2dm_addr_o  out  ADDR_WIDTH  request address.
- dmi2dm_wdata_o  out  32  write data.
- dm2dmi_resp_i  in  1  DM response strobe.
- dm2dmi_err_i  in  1  DM error, valid with resp.
- dm2dmi_rdata_i  in  32  read data, valid with resp.

Function
REQ-005 DR widths: DTMCS = 32; DMI_ACCESS = ADDR_WIDTH+34, fields op[1:0], data[33:2], addr[ADDR_WIDTH+33:34].
REQ-006 Shift register SHALL load on capture and shift right on shift, TDI entering the MSB of the selected DR width; tdo = bit 0, registered.
REQ-007 DTMCS capture value: version=1 [3:0], abits=ADDR_WIDTH [9:4], dmistat=sticky status [11:10], idle=IDLE_HINT [14:12], others 0.
REQ-008 DMI_ACCESS capture value: addr=last request address, data=read-data register, op=sticky status; if FSM is BUSY, op=3 and sticky is set to 3.
REQ-009 Sticky status encoding: 0 ok, 2 failed, 3 busy; a nonzero value is only overwritten by a reset, dmireset or dmihardreset.
REQ-010 FSM states: IDLE, BUSY.
REQ-011 DMI update (sel & update & id==2) in IDLE with sticky==0 and op in {1,2}: capture addr/wdata/wr; enter BUSY next cycle; req=1 from the next cycle.
REQ-012 DMI update with op==0, or with sticky!=0, SHALL NOT issue a request.
REQ-013 DMI update in BUSY SHALL set sticky=3 and SHALL leave the in-flight request unchanged.
REQ-014 In BUSY, req, wr, addr and wdata SHALL hold stable until resp is sampled high.
REQ-015 When resp is sampled high in BUSY: return to IDLE; req=0 in the following cycle.
REQ-016 On that resp: if err=1, sticky=2 and the data register is unchanged; else if read, the data register loads rdata.
REQ-017 resp outside BUSY SHALL be ignored.
REQ-018 DTMCS update with bit16 (dmireset)=1: sticky:=0; the in-flight request continues.
REQ-019 DTMCS update with bit17 (dmihardreset)=1: sticky:=0, FSM:=IDLE, req deasserted next cycle; later resp is ignored. Takes precedence over bit16.
REQ-020 resp and dmihardreset in the same cycle: hardreset wins; the data register is unchanged.
REQ-021 When req=0: wr, addr and wdata outputs SHALL be 0.
REQ-022 Capture and update SHALL NOT occur in the same cycle; behaviour if they do is unspecified.

Reset
REQ-023 rst SHALL asynchronously force: FSM IDLE; req, wr, addr, wdata = 0; tdo = 0.
REQ-024 rst SHALL also clear: shift register, data register, last address and sticky status to 0.
REQ-025 rst asserted while BUSY: request dropped immediately; no response is expected afterwards.
REQ-026 Deassertion SHALL be usable asynchronously; the first update is accepted one cycle after deassertion.

Configuration
REQ-027 Macro SCR1_DMI_HS_TIMEOUT_EN selects the timeout feature.
REQ-028 Without SCR1_DMI_HS_TIMEOUT_EN: BUSY waits indefinitely for resp.
REQ-029 With SCR1_DMI_HS_TIMEOUT_EN: a counter clears on entering BUSY and increments each BUSY cycle. On reaching TIMEOUT_CYCLES without resp: sticky=2, FSM to IDLE, req=0 next cycle. resp in the timeout cycle wins.

Verification
REQ-030 Capture DTMCS, ADDR_WIDTH=7, IDLE_HINT=1 -> shifted-out word 0x00001071.
REQ-031 DMI read addr 0x11; resp after 3 cycles with rdata 0xDEADBEEF -> req high exactly 4 cycles, wr=0; next DMI capture data=0xDEADBEEF, op=0.
REQ-032 DMI write during BUSY -> no second req; capture op=3; write stays blocked until DTMCS update with bit16 set, then write addr 0x10 issues req with wr=1.
REQ-033 Read with err=1 on resp -> capture op=2, data unchanged; DTMCS dmistat=2.
REQ-034 dmihardreset while BUSY, then resp 2 cycles later -> req low next cycle, data register unchanged, sticky 0.
REQ-035 With SCR1_DMI_HS_TIMEOUT_EN, TIMEOUT_CYCLES=8, no resp -> req drops after 8 BUSY cycles; capture op=2.
